m68k_bus_decoder: RTL

M68K_BUS_DECODER -- requirements
Module: m68k_bus_decoder

---
 rtl/m68k_bus_decoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/m68k_bus_decoder.sv
// rtl/m68k_bus_decoder.sv - 68000-style address decoder with wait-state, external-ready and bus-error timeout FSM.
// The winning region, its wait count and its ext flag are captured on the first AS edge, so table edits mid-cycle are harmless.
module m68k_bus_decoder #(
   parameter int NREG    = 16,
   parameter int AW      = 24,
   parameter int WSW     = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [AW-1:0]       cpu_a,
   input  logic                cpu_as_n,
   input  logic [NREG*AW-1:0]  reg_base,
   input  logic [NREG*5-1:0]   reg_width,
   input  logic [NREG*WSW-1:0] reg_ws,
   input  logic [NREG-1:0]     reg_en,
   input  logic [NREG-1:0]     reg_ext,
   input  logic [NREG-1:0]     ext_ready,
   output logic [NREG-1:0]     cs,
   output logic [4:0]          sel_idx,
   output logic                hit,
   output logic                dtack_n,
   output logic                berr_n,
   output logic                busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;
   localparam logic [1:0] ST_BERR = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [NREG-1:0] cs_q, cs_d;
   logic [4:0]      sel_idx_q, sel_idx_d;
   logic            hit_q, hit_d;
   logic            dtack_n_q, dtack_n_d;
   logic            berr_n_q, berr_n_d;
   logic [WSW-1:0]  wcnt_q, wcnt_d;
   logic [15:0]     tcnt_q, tcnt_d;
   logic            ext_q, ext_d;

   logic [NREG-1:0] match;
   logic [NREG-1:0] win_oh;
   logic [4:0]      win_idx;
   logic [WSW-1:0]  win_ws;
   logic            win_ext;
   logic            found;
   logic            ext_sel;
   logic            ready;

   always_comb begin
      match = '0;
      for (int i = 0; i < NREG; i++) begin
         match[i] = reg_en[i] && !cpu_as_n &&
                    ((cpu_a >> reg_width[i*5 +: 5]) ==
                     (reg_base[i*AW +: AW] >> reg_width[i*5 +: 5]));
      end
   end

   // Scan from the top down so the lowest matching index is the last write.
   always_comb begin
      found   = 1'b0;
      win_oh  = '0;
      win_idx = 5'd0;
      win_ws  = '0;
      win_ext = 1'b0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (match[i]) begin
            found     = 1'b1;
            win_oh    = '0;
            win_oh[i] = 1'b1;
            win_idx   = 5'(i);
            win_ws    = reg_ws[i*WSW +: WSW];
            win_ext   = reg_ext[i];
         end
      end
   end

   assign ext_sel = |(ext_ready & cs_q);
   assign ready   = hit_q && (wcnt_q == '0) && (!ext_q || ext_sel);

   always_comb begin
      state_d   = state_q;
      cs_d      = cs_q;
      sel_idx_d = sel_idx_q;
      hit_d     = hit_q;
      dtack_n_d = dtack_n_q;
      berr_n_d  = berr_n_q;
      wcnt_d    = wcnt_q;
      tcnt_d    = tcnt_q;
      ext_d     = ext_q;
      case (state_q)
         ST_IDLE: begin
            if (!cpu_as_n) begin
               state_d   = ST_WAIT;
               cs_d      = win_oh;
               sel_idx_d = win_idx;
               hit_d     = found;
               wcnt_d    = win_ws;
               ext_d     = win_ext;
               tcnt_d    = 16'd0;
            end
         end
         ST_WAIT: begin
            if (cpu_as_n) begin
               state_d = ST_IDLE;
            end else if (ready) begin
               state_d   = ST_ACK;
               dtack_n_d = 1'b0;
            end else if (tcnt_q == 16'(TIMEOUT)) begin
               state_d  = ST_BERR;
               berr_n_d = 1'b0;
            end else begin
               if (wcnt_q != '0) begin
                  wcnt_d = wcnt_q - 1'b1;
               end
               tcnt_d = tcnt_q + 16'd1;
            end
         end
         default: begin
            if (cpu_as_n) begin
               state_d = ST_IDLE;
            end
         end
      endcase

      // Every exit to IDLE drops the whole cycle context in one place.
      if (state_q != ST_IDLE && state_d == ST_IDLE) begin
         cs_d      = '0;
         sel_idx_d = 5'd0;
         hit_d     = 1'b0;
         dtack_n_d = 1'b1;
         berr_n_d  = 1'b1;
         wcnt_d    = '0;
         tcnt_d    = 16'd0;
         ext_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cs_q      <= '0;
         sel_idx_q <= 5'd0;
         hit_q     <= 1'b0;
         dtack_n_q <= 1'b1;
         berr_n_q  <= 1'b1;
         wcnt_q    <= '0;
         tcnt_q    <= 16'd0;
         ext_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cs_q      <= cs_d;
         sel_idx_q <= sel_idx_d;
         hit_q     <= hit_d;
         dtack_n_q <= dtack_n_d;
         berr_n_q  <= berr_n_d;
         wcnt_q    <= wcnt_d;
         tcnt_q    <= tcnt_d;
         ext_q     <= ext_d;
      end
   end

   assign cs      = cs_q;
   assign sel_idx = sel_idx_q;
   assign hit     = hit_q;
   assign dtack_n = dtack_n_q;
   assign berr_n  = berr_n_q;
   assign busy    = (state_q != ST_IDLE);

endmodule
